// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU-to-AXI3 bridge: FSM state encoding and the
// fixed AXI sideband values the SoC wrapper ties off.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Single-beat, incrementing, non-exclusive, unprotected, ID 0.
  localparam logic [3:0] AXI_LEN   = 4'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;
  localparam logic [3:0] AXI_ID    = 4'd0;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's sram-like request port to a 32-bit AXI3 slave, one
// transaction at a time. Request fields are latched on acceptance.
//
// Handshakes: the core's request is taken on a cycle where req && addr_ok;
// every AXI channel transfers on a cycle where its valid && ready are both
// high, and a raised valid is held with stable payload until that cycle.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [31:0]           r_data,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           w_data,
  output logic [3:0]            w_strb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready,
  output state_t                dbg_state
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           wdata_q;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_hs;
  logic                  w_hs;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign addr_ok   = (state == S_IDLE);
  assign dbg_state = state;

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = axi_size(size_q);
  assign awsize = axi_size(size_q);
  assign w_data = wdata_q;
  assign w_strb = wstrb_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            size_q  <= size;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            if (wr) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= S_AW_W;
            end else begin
              arvalid <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rdata   <= r_data;
            rready  <= 1'b0;
            data_ok <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_AW_W: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // Either channel may finish first, or both in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= S_B;
          end
        end
        S_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            data_ok <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
